case_route: RTL and testbench
=============================

# case_route

Parametrised select-and-dispatch stage: accepts one beat per handshake, decodes its select field through a fully specified case (explicit default arm), and presents the beat registered on exactly one of NUM_CH output channels. Unmatched select codes are dropped or redirected to a fallback channel, per MODE, and are flagged and counted. It sits between a command source and per-channel consumers, replacing ad-hoc combinational select decoders that leave unmatched codes undefined.

## Interface
- DATA_W, 8, payload width
- NUM_CH, 4, number of output channels (2..2**SEL_W)
- SEL_W, 3, select field width
- MODE, 0, 0 = drop illegal beats; 1 = route illegal beats to channel NUM_CH-1
- CNT_W, 8, illegal-beat counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sel  in  SEL_W  channel select
- in_data  in  DATA_W  payload
- out_valid  out  NUM_CH  one-hot channel valid
- out_ready  in  NUM_CH  per-channel ready
- out_data  out  DATA_W  registered payload, shared by all channels
- err_pulse  out  1  one-cycle flag per illegal beat
- err_count  out  CNT_W  saturating illegal-beat count
- clr_err  in  1  synchronous clear of err_count

## Operation
- States: IDLE, SEND, ERR. Reset: IDLE; out_valid=0, out_data=0, err_pulse=0, err_count=0; in_ready=1 after reset deasserts.
- Legal: in_sel < NUM_CH. Illegal: in_sel >= NUM_CH (explicit default arm; no latch, no X).
- in_ready = (IDLE) || (SEND && out_ready[cur_ch]); in_ready = 0 in ERR.
- IDLE, accept legal: SEND, cur_ch=in_sel, out_data=in_data, out_valid=onehot(in_sel).
- IDLE, accept illegal, MODE 0: ERR, data dropped, out_valid stays 0. MODE 1: SEND on channel NUM_CH-1 and also err_pulse=1 for that cycle; no ERR state.
- SEND: out_valid and out_data held stable until out_ready[cur_ch]. On that handshake, a simultaneous accepted beat loads directly (legal: stay SEND; illegal MODE 0: ERR; MODE 1: SEND on fallback channel); otherwise IDLE.
- ERR: lasts exactly one cycle, err_pulse=1, then IDLE.
- out_ready on channels other than cur_ch is ignored.
- err_count increments by 1 per illegal beat accepted, saturates at 2**CNT_W-1. clr_err has priority: clear and increment in the same cycle yield 0.
- rst mid-operation: pending beat lost, all outputs return to reset values asynchronously.

## Timing
- Latency: accept edge to out_valid = 1 cycle.
- Throughput: 1 beat/cycle while consumers keep ready high (back-to-back through SEND).
- Illegal beat, MODE 0: 2-cycle bubble (ERR cycle plus reaccept in IDLE); err_pulse in the cycle after acceptance.
- err_count visible updated 1 cycle after acceptance.
- No combinational path from in_valid/in_data to any output; in_ready depends combinationally only on state and out_ready.

## Structure
- case_route_pkg: state typedef enum {IDLE, SEND, ERR}; MODE_DROP=0, MODE_FALLBACK=1 constants.
- Sub-module sat_counter (CNT_W, inc, clr, count) for err_count; everything else in case_route.
- Every case in the block carries an explicit default arm; every always_comb assigns defaults before its case.

## Test plan
- Reset, NUM_CH=4: in_sel=2, in_data=0xA5, out_ready=4'b0100 -> next cycle out_valid=4'b0100, out_data=0xA5, then IDLE.
- Backpressure: in_sel=1 with out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0; ready rises -> handshake, next beat accepted same cycle.
- Back-to-back: 8 beats, sel 0..3 repeating, all ready high -> 8 beats out in 8 consecutive cycles, correct channel each.
- MODE 0 illegal: in_sel=6 -> out_valid stays 0, err_pulse 1 cycle, err_count=1, in_ready low 1 cycle.
- MODE 1 illegal: in_sel=7, data 0x3C -> out_valid=4'b1000, out_data=0x3C, err_pulse=1, err_count=1.
- CNT_W=2: 5 illegal beats -> err_count=3; clr_err together with an illegal beat -> 0; async rst during SEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/case_route_pkg.sv
// Shared types and constants for the case_route select-and-dispatch stage.
package case_route_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam int MODE_DROP     = 0;
  localparam int MODE_FALLBACK = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/case_route.sv
// Select-and-dispatch stage: one registered beat presented on exactly one of NUM_CH channels.
// Handshake: a beat moves on a rising edge where valid && ready; valid holds data stable until then.
module case_route
  import case_route_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 3,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SEL_W:0]    NUM_CH_L    = NUM_CH[SEL_W:0];
  localparam logic [CH_W-1:0]   FALLBACK_CH = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH0         = NUM_CH'(1);

  state_t          state;
  logic [CH_W-1:0] cur_ch;
  logic            sel_legal;
  logic [CH_W-1:0] sel_ch;
  logic            illegal_acc;

  // Unmatched codes resolve to the fallback channel so nothing is ever undefined.
  always_comb begin
    sel_legal = 1'b0;
    sel_ch    = FALLBACK_CH;
    case ({1'b0, in_sel} < NUM_CH_L)
      1'b1: begin
        sel_legal = 1'b1;
        sel_ch    = in_sel[CH_W-1:0];
      end
      default: begin
        sel_legal = 1'b0;
        sel_ch    = FALLBACK_CH;
      end
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      SEND:    in_ready = out_ready[cur_ch];
      default: in_ready = 1'b0;
    endcase
  end

  assign illegal_acc = in_valid && in_ready && !sel_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_ch    <= '0;
      out_valid <= '0;
      out_data  <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, SEND: begin
          // In SEND, in_ready doubles as the output handshake for cur_ch.
          if (in_ready) begin
            if (in_valid) begin
              if (sel_legal || (MODE == MODE_FALLBACK)) begin
                state     <= SEND;
                cur_ch    <= sel_ch;
                out_data  <= in_data;
                out_valid <= CH0 << sel_ch;
                err_pulse <= !sel_legal;
              end else begin
                state     <= ERR;
                out_valid <= '0;
                err_pulse <= 1'b1;
              end
            end else begin
              state     <= IDLE;
              out_valid <= '0;
            end
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (illegal_acc),
    .clr  (clr_err),
    .count(err_count)
  );

endmodule

// File: tb/tb_case_route.sv
// Bench for case_route: drop-mode, fallback-mode and 2-bit-counter instances share one stimulus bus.
module tb_case_route;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_sel;
  logic [7:0] in_data;
  logic [3:0] out_ready;
  logic       clr_err;

  logic       d_in_ready, f_in_ready, s_in_ready;
  logic [3:0] d_out_valid, f_out_valid, s_out_valid;
  logic [7:0] d_out_data, f_out_data, s_out_data;
  logic       d_err_pulse, f_err_pulse, s_err_pulse;
  logic [7:0] d_err_count, f_err_count;
  logic [1:0] s_err_count;

  logic [11:0] exp_q[$];
  int checks;
  int errors;
  int cyc;
  int out_beats;

  case_route #(.DATA_W(8), .NUM_CH(4), .SEL_W(3), .MODE(0), .CNT_W(8)) u_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
    .err_pulse(d_err_pulse), .err_count(d_err_count), .clr_err(clr_err));

  case_route #(.DATA_W(8), .NUM_CH(4), .SEL_W(3), .MODE(1), .CNT_W(8)) u_fb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data),
    .err_pulse(f_err_pulse), .err_count(f_err_count), .clr_err(clr_err));

  case_route #(.DATA_W(8), .NUM_CH(4), .SEL_W(3), .MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_sel(in_sel),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .err_pulse(s_err_pulse), .err_count(s_err_count), .clr_err(clr_err));

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard monitor for the drop-mode instance
  always @(negedge clk) begin
    logic [11:0] got;
    logic [11:0] exp;
    if (!rst && (d_out_valid & out_ready) != 4'b0000) begin
      got = {d_out_valid, d_out_data};
      checks++;
      out_beats++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h required none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_beat got %h required %h", got, exp);
        end
      end
    end
  end

  // driver: present one beat until the selected instance accepts it
  task automatic send(input int which, input logic [2:0] sel, input logic [7:0] data);
    logic rdy;
    logic [3:0] one;
    bit done;
    one = 4'b0001;
    done = 0;
    in_valid = 1'b1;
    in_sel = sel;
    in_data = data;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      rdy = (which == 0) ? d_in_ready : (which == 1) ? f_in_ready : s_in_ready;
      if (d_in_ready && sel < 3'd4) exp_q.push_back({one << sel, data});
      if (rdy) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no in_ready required accept (sel %0d)", sel);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 3'd0;
    in_data = 8'h00;
    out_ready = 4'b0000;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (d_out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b required 0000", d_out_valid); end
    checks++; if (d_out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h required 00", d_out_data); end
    checks++; if (d_err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %b required 0", d_err_pulse); end
    checks++; if (d_err_count !== 8'h00) begin errors++; $display("FAIL reset_err_count got %h required 00", d_err_count); end
    checks++; if (f_out_valid !== 4'b0000) begin errors++; $display("FAIL reset_fb_out_valid got %b required 0000", f_out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", d_in_ready); end
  endtask

  task automatic test_basic();
    @(posedge clk);
    #1;
    out_ready = 4'b0100;
    send(0, 3'd2, 8'hA5);
    checks++; if (d_out_valid !== 4'b0100) begin errors++; $display("FAIL basic_out_valid got %b required 0100", d_out_valid); end
    checks++; if (d_out_data !== 8'hA5) begin errors++; $display("FAIL basic_out_data got %h required a5", d_out_data); end
    @(posedge clk);
    #1;
    checks++; if (d_out_valid !== 4'b0000) begin errors++; $display("FAIL basic_idle_valid got %b required 0000", d_out_valid); end
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got %b required 1", d_in_ready); end
  endtask

  task automatic test_backpressure();
    int start;
    out_ready = 4'b0000;
    send(0, 3'd1, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // ready on a non-selected channel must not release the beat
      checks++; if (d_out_valid !== 4'b0010) begin errors++; $display("FAIL bp_out_valid got %b required 0010", d_out_valid); end
      checks++; if (d_out_data !== 8'h5A) begin errors++; $display("FAIL bp_out_data got %h required 5a", d_out_data); end
      checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b required 0", d_in_ready); end
      @(posedge clk);
      #1;
      out_ready = 4'b1101;
    end
    out_ready = 4'b1111;
    start = cyc;
    send(0, 3'd3, 8'h77);
    checks++; if (cyc - start !== 1) begin errors++; $display("FAIL bp_reaccept_cycles got %0d required 1", cyc - start); end
    checks++; if (d_out_valid !== 4'b1000) begin errors++; $display("FAIL bp_next_valid got %b required 1000", d_out_valid); end
    checks++; if (d_out_data !== 8'h77) begin errors++; $display("FAIL bp_next_data got %h required 77", d_out_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int start;
    int beats0;
    logic [2:0] sel;
    logic [3:0] one;
    one = 4'b0001;
    out_ready = 4'b1111;
    start = cyc;
    beats0 = out_beats;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i % 4);
      send(0, sel, 8'($urandom_range(0, 255)));
      checks++; if (d_out_valid !== (one << sel)) begin errors++; $display("FAIL b2b_channel got %b required %b", d_out_valid, one << sel); end
    end
    checks++; if (cyc - start !== 8) begin errors++; $display("FAIL b2b_cycles got %0d required 8", cyc - start); end
    @(posedge clk);
    #1;
    checks++; if (out_beats - beats0 !== 8) begin errors++; $display("FAIL b2b_beats got %0d required 8", out_beats - beats0); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_queue got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_illegal_drop();
    reset_dut();
    out_ready = 4'b1111;
    send(0, 3'd6, 8'h99);
    checks++; if (d_err_pulse !== 1'b1) begin errors++; $display("FAIL drop_err_pulse got %b required 1", d_err_pulse); end
    checks++; if (d_in_ready !== 1'b0) begin errors++; $display("FAIL drop_in_ready got %b required 0", d_in_ready); end
    checks++; if (d_out_valid !== 4'b0000) begin errors++; $display("FAIL drop_out_valid got %b required 0000", d_out_valid); end
    checks++; if (d_err_count !== 8'd1) begin errors++; $display("FAIL drop_err_count got %0d required 1", d_err_count); end
    @(posedge clk);
    #1;
    checks++; if (d_err_pulse !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b required 0", d_err_pulse); end
    checks++; if (d_in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_back got %b required 1", d_in_ready); end
    checks++; if (d_out_valid !== 4'b0000) begin errors++; $display("FAIL drop_valid_after got %b required 0000", d_out_valid); end
  endtask

  task automatic test_illegal_fallback();
    reset_dut();
    out_ready = 4'b0000;
    send(1, 3'd7, 8'h3C);
    checks++; if (f_out_valid !== 4'b1000) begin errors++; $display("FAIL fb_out_valid got %b required 1000", f_out_valid); end
    checks++; if (f_out_data !== 8'h3C) begin errors++; $display("FAIL fb_out_data got %h required 3c", f_out_data); end
    checks++; if (f_err_pulse !== 1'b1) begin errors++; $display("FAIL fb_err_pulse got %b required 1", f_err_pulse); end
    checks++; if (f_err_count !== 8'd1) begin errors++; $display("FAIL fb_err_count got %0d required 1", f_err_count); end
    @(posedge clk);
    #1;
    checks++; if (f_err_pulse !== 1'b0) begin errors++; $display("FAIL fb_pulse_end got %b required 0", f_err_pulse); end
    checks++; if (f_out_valid !== 4'b1000) begin errors++; $display("FAIL fb_hold got %b required 1000", f_out_valid); end
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    checks++; if (f_out_valid !== 4'b0000) begin errors++; $display("FAIL fb_release got %b required 0000", f_out_valid); end
  endtask

  task automatic test_saturate_and_reset();
    reset_dut();
    out_ready = 4'b1111;
    for (int i = 0; i < 5; i++) send(2, 3'd5, 8'($urandom_range(0, 255)));
    @(posedge clk);
    #1;
    checks++; if (s_err_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d required 3", s_err_count); end
    checks++; if (d_err_count !== 8'd5) begin errors++; $display("FAIL wide_count got %0d required 5", d_err_count); end
    clr_err = 1'b1;
    send(2, 3'd5, 8'h11);
    clr_err = 1'b0;
    checks++; if (s_err_count !== 2'd0) begin errors++; $display("FAIL clr_priority got %0d required 0", s_err_count); end
    checks++; if (d_err_count !== 8'd0) begin errors++; $display("FAIL clr_wide got %0d required 0", d_err_count); end
    @(posedge clk);
    #1;
    send(2, 3'd4, 8'h22);
    @(posedge clk);
    #1;
    out_ready = 4'b0000;
    send(0, 3'd0, 8'hE7);
    checks++; if (d_out_valid !== 4'b0001) begin errors++; $display("FAIL rst_pre_valid got %b required 0001", d_out_valid); end
    checks++; if (d_err_count !== 8'd1) begin errors++; $display("FAIL rst_pre_count got %0d required 1", d_err_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (d_out_valid !== 4'b0000) begin errors++; $display("FAIL async_rst_valid got %b required 0000", d_out_valid); end
    checks++; if (d_out_data !== 8'h00) begin errors++; $display("FAIL async_rst_data got %h required 00", d_out_data); end
    checks++; if (d_err_count !== 8'd0) begin errors++; $display("FAIL async_rst_count got %0d required 0", d_err_count); end
    checks++; if (s_err_count !== 2'd0) begin errors++; $display("FAIL async_rst_sat got %0d required 0", s_err_count); end
    checks++; if (d_err_pulse !== 1'b0) begin errors++; $display("FAIL async_rst_pulse got %b required 0", d_err_pulse); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    out_beats = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_illegal_drop();
    test_illegal_fallback();
    test_saturate_and_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
